err_monitor: RTL and testbench

ERR_MONITOR -- requirements
Module: err_monitor

---
 rtl/err_monitor_if.sv | 31 +++
 rtl/err_monitor.sv | 129 ++++++++++++
 tb/tb_err_monitor.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/err_monitor_if.sv
// Retire-stream and error-report signals between the core and err_monitor.
// The master drives retires and consumes reports; the slave is the monitor.
interface err_monitor_if;
    logic        instr_valid_i;
    logic        err_num_i;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic        mem_en_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_size_i;
    logic        halt_instr_i;
    logic        err_ready_i;
    logic        err_valid_o;
    logic [3:0]  err_code_o;
    logic [31:0] err_cycle_o;
    logic        stall_o;
    logic        halted_o;
    logic        overrun_o;

    modport master (
        output instr_valid_i, err_num_i, wr_en_i, wr_addr_i, mem_en_i,
               mem_addr_i, mem_size_i, halt_instr_i, err_ready_i,
        input  err_valid_o, err_code_o, err_cycle_o, stall_o, halted_o, overrun_o
    );

    modport slave (
        input  instr_valid_i, err_num_i, wr_en_i, wr_addr_i, mem_en_i,
               mem_addr_i, mem_size_i, halt_instr_i, err_ready_i,
        output err_valid_o, err_code_o, err_cycle_o, stall_o, halted_o, overrun_o
    );
endinterface

// File: rtl/err_monitor.sv
// Watches retiring instructions for architectural errors, reports them one at a
// time through a valid/ready handshake and halts the core on fatal memory faults.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | accepting retires, no report outstanding
// REPORT    | non-fatal report held, core stalled until consumer accepts
// HALT_PEND | report held, halt follows once consumer accepts
// HALTED    | core stopped; only reset leaves this state
module err_monitor #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    err_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        REPORT    = 2'd1,
        HALT_PEND = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [32:0] ADDR_LIMIT_W = 33'(ADDR_LIMIT);

    state_t      state;
    logic [31:0] retire_cnt;
    logic        err_valid;
    logic [3:0]  err_code;
    logic [31:0] err_cycle;
    logic        stall;
    logic        halted;
    logic        overrun;

    logic        accept;
    logic [2:0]  size_bytes;
    logic [32:0] access_end;
    logic        write_zero;
    logic        num_ovf;
    logic        mem_ovf;
    logic        misalign;
    logic [3:0]  flags;
    logic        fatal;

    assign accept = mon.instr_valid_i & ~stall & ~halted;

    always_comb begin
        size_bytes = 3'd4;
        case (mon.mem_size_i)
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    end

    // 33-bit sum so an access straddling 2^32 cannot wrap back into range
    assign access_end = {1'b0, mon.mem_addr_i} + {30'd0, size_bytes};

    assign write_zero = mon.wr_en_i & (mon.wr_addr_i == 5'd0);
    assign num_ovf    = mon.err_num_i;
    assign mem_ovf    = mon.mem_en_i & (access_end > ADDR_LIMIT_W);
    assign misalign   = mon.mem_en_i &
                        (((mon.mem_size_i == 2'b01) & mon.mem_addr_i[0]) |
                         (mon.mem_size_i[1] & (mon.mem_addr_i[1:0] != 2'b00)));
    assign flags      = {misalign, mem_ovf, num_ovf, write_zero};
    assign fatal      = misalign | mem_ovf;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= RUN;
            retire_cnt <= 32'd0;
            err_valid  <= 1'b0;
            err_code   <= 4'd0;
            err_cycle  <= 32'd0;
            stall      <= 1'b0;
            halted     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (mon.instr_valid_i && (stall || halted))
                overrun <= 1'b1;
            if (accept && retire_cnt != 32'hFFFF_FFFF)
                retire_cnt <= retire_cnt + 32'd1;

            case (state)
                RUN: begin
                    if (accept) begin
                        if (flags != 4'd0) begin
                            err_code  <= flags;
                            err_cycle <= retire_cnt;
                            err_valid <= 1'b1;
                            stall     <= 1'b1;
                            state     <= (fatal || mon.halt_instr_i) ? HALT_PEND : REPORT;
                        end else if (mon.halt_instr_i) begin
                            stall  <= 1'b1;
                            halted <= 1'b1;
                            state  <= HALTED;
                        end
                    end
                end
                REPORT: begin
                    if (mon.err_ready_i) begin
                        err_valid <= 1'b0;
                        stall     <= 1'b0;
                        state     <= RUN;
                    end
                end
                HALT_PEND: begin
                    if (mon.err_ready_i) begin
                        err_valid <= 1'b0;
                        halted    <= 1'b1;
                        state     <= HALTED;
                    end
                end
                HALTED: begin
                    stall  <= 1'b1;
                    halted <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign mon.err_valid_o = err_valid;
    assign mon.err_code_o  = err_code;
    assign mon.err_cycle_o = err_cycle;
    assign mon.stall_o     = stall;
    assign mon.halted_o    = halted;
    assign mon.overrun_o   = overrun;
endmodule

// File: tb/tb_err_monitor.sv
// Directed bench for err_monitor: retire sequences with hand-computed report
// codes, retire indices, stall/halt/overrun behaviour and reset recovery.
module tb_err_monitor;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    err_monitor_if bus ();

    err_monitor #(.ADDR_LIMIT(1024)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .mon   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.instr_valid_i = 1'b0;
        bus.err_num_i     = 1'b0;
        bus.wr_en_i       = 1'b0;
        bus.wr_addr_i     = 5'd0;
        bus.mem_en_i      = 1'b0;
        bus.mem_addr_i    = 32'd0;
        bus.mem_size_i    = 2'b00;
        bus.halt_instr_i  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic set_retire(input logic wen, input logic [4:0] waddr, input logic numo,
                              input logic men, input logic [31:0] addr,
                              input logic [1:0] size, input logic halt);
        bus.instr_valid_i = 1'b1;
        bus.wr_en_i       = wen;
        bus.wr_addr_i     = waddr;
        bus.err_num_i     = numo;
        bus.mem_en_i      = men;
        bus.mem_addr_i    = addr;
        bus.mem_size_i    = size;
        bus.halt_instr_i  = halt;
    endtask

    task automatic retire(input logic wen, input logic [4:0] waddr, input logic numo,
                          input logic men, input logic [31:0] addr,
                          input logic [1:0] size, input logic halt);
        set_retire(wen, waddr, numo, men, addr, size, halt);
        tick();
        idle_inputs();
    endtask

    task automatic ack();
        bus.err_ready_i = 1'b1;
        tick();
        bus.err_ready_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   32'(bus.err_valid_o), 32'd0);
        check({tag, "_code"},    32'(bus.err_code_o),  32'd0);
        check({tag, "_cycle"},   bus.err_cycle_o,      32'd0);
        check({tag, "_stall"},   32'(bus.stall_o),     32'd0);
        check({tag, "_halted"},  32'(bus.halted_o),    32'd0);
        check({tag, "_overrun"}, 32'(bus.overrun_o),   32'd0);
    endtask

    initial begin
        idle_inputs();
        bus.err_ready_i = 1'b0;
        do_reset();
        check_all_zero("rst");

        // three clean retires (indices 0..2), then write to x0 at index 3
        for (int i = 0; i < 3; i++) retire(1'b1, 5'd3, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        check("clean_valid", 32'(bus.err_valid_o), 32'd0);
        check("clean_stall", 32'(bus.stall_o), 32'd0);
        retire(1'b1, 5'd0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        check("wz_valid", 32'(bus.err_valid_o), 32'd1);
        check("wz_code",  32'(bus.err_code_o),  32'h1);
        check("wz_cycle", bus.err_cycle_o,      32'd3);
        check("wz_stall", 32'(bus.stall_o),     32'd1);
        tick();
        check("wz_hold_code",  32'(bus.err_code_o),  32'h1);
        check("wz_hold_valid", 32'(bus.err_valid_o), 32'd1);
        ack();
        check("wz_ack_valid", 32'(bus.err_valid_o), 32'd0);
        check("wz_ack_stall", 32'(bus.stall_o),     32'd0);

        retire(1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0);
        check("num_code",  32'(bus.err_code_o), 32'h2);
        check("num_cycle", bus.err_cycle_o,     32'd4);
        ack();

        // report at index 5, then retires presented during the stall
        retire(1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_retire(1'b1, 5'd0, 1'b0, 1'b1, 32'd3, 2'b10, 1'b0);
            tick();
        end
        idle_inputs();
        check("ovr_code",    32'(bus.err_code_o),  32'h2);
        check("ovr_cycle",   bus.err_cycle_o,      32'd5);
        check("ovr_valid",   32'(bus.err_valid_o), 32'd1);
        check("ovr_overrun", 32'(bus.overrun_o),   32'd1);
        check("ovr_halted",  32'(bus.halted_o),    32'd0);
        ack();
        retire(1'b1, 5'd0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        check("ovr_next_cycle", bus.err_cycle_o, 32'd6);
        check("ovr_sticky",     32'(bus.overrun_o), 32'd1);
        ack();

        retire(1'b0, 5'd0, 1'b0, 1'b1, 32'd1020, 2'b10, 1'b0);
        check("w1020_valid", 32'(bus.err_valid_o), 32'd0);
        check("w1020_stall", 32'(bus.stall_o),     32'd0);

        // index 8: write_zero + num_ovf + misaligned half in one instruction
        retire(1'b1, 5'd0, 1'b1, 1'b1, 32'd1, 2'b01, 1'b0);
        check("multi_code",   32'(bus.err_code_o), 32'hB);
        check("multi_cycle",  bus.err_cycle_o,     32'd8);
        check("multi_stall",  32'(bus.stall_o),    32'd1);
        check("multi_halted", 32'(bus.halted_o),   32'd0);
        ack();
        check("multi_ack_halted", 32'(bus.halted_o),    32'd1);
        check("multi_ack_valid",  32'(bus.err_valid_o), 32'd0);
        check("multi_ack_stall",  32'(bus.stall_o),     32'd1);
        repeat (3) tick();
        check("halted_stays", 32'(bus.halted_o), 32'd1);
        do_reset();
        check_all_zero("rst_halted");

        // aligned word near the top of the 32-bit space must not wrap
        retire(1'b0, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFC, 2'b10, 1'b0);
        check("wrap_code",  32'(bus.err_code_o), 32'h4);
        check("wrap_cycle", bus.err_cycle_o,     32'd0);
        ack();
        check("wrap_halted", 32'(bus.halted_o), 32'd1);
        do_reset();

        retire(1'b0, 5'd0, 1'b0, 1'b1, 32'd1022, 2'b10, 1'b0);
        check("w1022_code",   32'(bus.err_code_o),  32'hC);
        check("w1022_valid",  32'(bus.err_valid_o), 32'd1);
        check("w1022_halted", 32'(bus.halted_o),    32'd0);
        do_reset();
        check_all_zero("rst_pend");
        retire(1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0);
        check("post_rst_cycle", bus.err_cycle_o, 32'd0);
        ack();

        // size boundaries: byte@1023 and half@1022 legal, size 11 acts as word
        retire(1'b0, 5'd0, 1'b0, 1'b1, 32'd1023, 2'b00, 1'b0);
        retire(1'b0, 5'd0, 1'b0, 1'b1, 32'd1022, 2'b01, 1'b0);
        check("edge_valid", 32'(bus.err_valid_o), 32'd0);
        retire(1'b0, 5'd0, 1'b0, 1'b1, 32'd6, 2'b11, 1'b0);
        check("sz3_code",  32'(bus.err_code_o), 32'h8);
        check("sz3_cycle", bus.err_cycle_o,     32'd3);
        do_reset();
        retire(1'b0, 5'd0, 1'b0, 1'b1, 32'd1023, 2'b01, 1'b0);
        check("h1023_code", 32'(bus.err_code_o), 32'hC);
        do_reset();

        // non-fatal flag with halt goes through HALT_PEND
        retire(1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b1);
        check("nfh_code",   32'(bus.err_code_o),  32'h2);
        check("nfh_valid",  32'(bus.err_valid_o), 32'd1);
        check("nfh_halted", 32'(bus.halted_o),    32'd0);
        ack();
        check("nfh_ack_halted", 32'(bus.halted_o), 32'd1);
        do_reset();

        // clean halt: no report, then a retire while halted flags overrun
        retire(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b1);
        check("halt_halted", 32'(bus.halted_o),    32'd1);
        check("halt_valid",  32'(bus.err_valid_o), 32'd0);
        check("halt_stall",  32'(bus.stall_o),     32'd1);
        retire(1'b1, 5'd0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0);
        check("halt_overrun", 32'(bus.overrun_o),   32'd1);
        check("halt_noreport", 32'(bus.err_valid_o), 32'd0);
        do_reset();
        check_all_zero("rst_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
